// File: rtl/flappy_ctrl_pkg.sv
// Shared types and default constants for the FlappyBird input/reset sequencer.
package flappy_ctrl_pkg;

  typedef enum logic [1:0] {
    S_POR,
    S_GUARD,
    S_RUN,
    S_RST
  } state_t;

  localparam int unsigned FRAME_W          = 8;
  localparam int unsigned DEF_DEB_CYCLES   = 65536;
  localparam int unsigned DEF_POR_FRAMES   = 8;
  localparam int unsigned DEF_RESET_FRAMES = 4;
  localparam int unsigned DEF_GUARD_FRAMES = 2;
  localparam int unsigned DEF_FLAP_FRAMES  = 2;
  localparam bit          DEF_VS_POL       = 1'b0;
  localparam int unsigned DEF_VS_TIMEOUT   = 1048576;

endpackage

// File: rtl/input_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-count debounce and a
// one-cycle registered pulse on each debounced rising edge.
module input_debounce
  import flappy_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      // Level follows the synchronised input only after an unbroken run of differences
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/flappy_ctrl_seq.sv
// Input and reset sequencer for the FlappyBird core: frame-aligned reset,
// post-reset guard interval and minimum-width flap pulses.
module flappy_ctrl_seq
  import flappy_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned POR_FRAMES   = DEF_POR_FRAMES,
  parameter int unsigned RESET_FRAMES = DEF_RESET_FRAMES,
  parameter int unsigned GUARD_FRAMES = DEF_GUARD_FRAMES,
  parameter int unsigned FLAP_FRAMES  = DEF_FLAP_FRAMES,
  parameter bit          VS_POL       = DEF_VS_POL,
  parameter int unsigned VS_TIMEOUT   = DEF_VS_TIMEOUT
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               fire_flap,
  input  logic               fire_reset,
  input  logic               osd_reset,
  input  logic               vs,
  output logic               game_reset_n,
  output logic               game_button_n,
  output logic               busy,
  output logic [FRAME_W-1:0] flap_count
);

  localparam int unsigned TO_W = $clog2(VS_TIMEOUT + 1);

  logic flap_rise;
  logic rst_rise;

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_flap_deb (
    .clk  (clk_sys),
    .rst  (reset),
    .din  (fire_flap),
    .rise (flap_rise)
  );

  input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_reset_deb (
    .clk  (clk_sys),
    .rst  (reset),
    .din  (fire_reset),
    .rise (rst_rise)
  );

  // Frame tick: vsync edge into the active level, or a synthetic tick on timeout
  logic            vs_s1;
  logic            vs_s2;
  logic            vs_d;
  logic            tick;
  logic [TO_W-1:0] to_cnt;
  logic            tick_set;
  logic            osd_d;
  logic            osd_rise;

  assign tick_set = ((vs_s2 == VS_POL) && (vs_d != VS_POL)) ||
                    (to_cnt == TO_W'(VS_TIMEOUT - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vs_s1    <= 1'b0;
      vs_s2    <= 1'b0;
      vs_d     <= 1'b0;
      tick     <= 1'b0;
      to_cnt   <= '0;
      osd_d    <= 1'b0;
      osd_rise <= 1'b0;
    end else begin
      vs_s1    <= vs;
      vs_s2    <= vs_s1;
      vs_d     <= vs_s2;
      tick     <= tick_set;
      to_cnt   <= tick_set ? '0 : to_cnt + TO_W'(1);
      osd_d    <= osd_reset;
      osd_rise <= osd_reset & ~osd_d;
    end
  end

  logic reset_req;
  assign reset_req = rst_rise | osd_rise;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [FRAME_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [FRAME_W-1:0] flap_count_nxt;
  logic               pulse_active, pulse_active_nxt;
  logic               game_reset_n_nxt;
  logic               game_button_n_nxt;
  logic               busy_nxt;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= S_POR;
      frame_cnt     <= '0;
      pulse_cnt     <= '0;
      pulse_active  <= 1'b0;
      flap_count    <= '0;
      game_reset_n  <= 1'b0;
      game_button_n <= 1'b1;
      busy          <= 1'b1;
    end else begin
      state         <= state_nxt;
      frame_cnt     <= frame_cnt_nxt;
      pulse_cnt     <= pulse_cnt_nxt;
      pulse_active  <= pulse_active_nxt;
      flap_count    <= flap_count_nxt;
      game_reset_n  <= game_reset_n_nxt;
      game_button_n <= game_button_n_nxt;
      busy          <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    frame_cnt_nxt    = tick ? frame_cnt + FRAME_W'(1) : frame_cnt;
    pulse_cnt_nxt    = pulse_cnt;
    pulse_active_nxt = pulse_active;
    flap_count_nxt   = flap_count;

    unique case (state)
      S_POR:   if (tick && (frame_cnt + FRAME_W'(1) == FRAME_W'(POR_FRAMES)))   state_nxt = S_GUARD;
      S_GUARD: if (tick && (frame_cnt + FRAME_W'(1) == FRAME_W'(GUARD_FRAMES))) state_nxt = S_RUN;
      S_RUN:   if (reset_req)                                                   state_nxt = S_RST;
      S_RST:   if (tick && (frame_cnt + FRAME_W'(1) == FRAME_W'(RESET_FRAMES))) state_nxt = S_GUARD;
      default: state_nxt = S_POR;
    endcase

    if (state_nxt != state) frame_cnt_nxt = '0;

    // Flap pulse: edges during an active pulse are dropped; a reset request wins
    if (pulse_active) begin
      if (tick) begin
        if (pulse_cnt + FRAME_W'(1) == FRAME_W'(FLAP_FRAMES)) begin
          pulse_active_nxt = 1'b0;
          pulse_cnt_nxt    = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt + FRAME_W'(1);
        end
      end
    end else if ((state == S_RUN) && flap_rise && !reset_req) begin
      pulse_active_nxt = 1'b1;
      pulse_cnt_nxt    = '0;
      flap_count_nxt   = flap_count + FRAME_W'(1);
    end

    if (state_nxt != S_RUN) begin
      pulse_active_nxt = 1'b0;
      pulse_cnt_nxt    = '0;
    end

    game_reset_n_nxt  = (state_nxt == S_GUARD) || (state_nxt == S_RUN);
    game_button_n_nxt = !pulse_active_nxt;
    busy_nxt          = (state_nxt != S_RUN);
  end

endmodule
